// File: rtl/proc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle control unit:
// opcodes, function codes, datapath select codes and FSM states.
package proc_ctrl_pkg;

    localparam logic [3:0] OP_FUNC  = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BE    = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_ORI   = 4'b0110;
    localparam logic [3:0] OP_NANDI = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_ADDIZ = 4'b1010;
    localparam logic [3:0] OP_NAND  = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_SUBIZ = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1111;

    localparam logic [3:0] FUNC_SHL = 4'b0001;
    localparam logic [3:0] FUNC_SHR = 4'b0010;
    localparam logic [3:0] FUNC_SAR = 4'b0011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SHL  = 3'b010;
    localparam logic [2:0] ALU_SHR  = 3'b011;
    localparam logic [2:0] ALU_SAR  = 3'b100;
    localparam logic [2:0] ALU_NAND = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_OFS = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_MEM = 3'd2,
        CLS_BR  = 3'd3,
        CLS_JMP = 3'd4,
        CLS_ILL = 3'd5
    } opclass_t;

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational instruction classifier: class, ALU operation and
// immediate extension mode from the IR opcode/function fields.
module ctrl_opclass
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] funcfield,
    output opclass_t   op_class,
    output logic [2:0] alu_op,
    output logic       ext_sel
);

    logic is_shift;
    logic is_r;
    logic is_i;
    logic is_mem;
    logic is_br;
    logic is_jmp;

    assign is_shift = (opcode == OP_FUNC) &&
                      (funcfield inside {FUNC_SHL, FUNC_SHR, FUNC_SAR});
    assign is_r   = is_shift ||
                    (opcode inside {OP_ADD, OP_NAND, OP_SUB, OP_OR});
    assign is_i   = opcode inside {OP_ADDI, OP_ADDIZ, OP_SUBI,
                                   OP_SUBIZ, OP_ORI, OP_NANDI};
    assign is_mem = opcode inside {OP_LW, OP_SW};
    assign is_br  = opcode inside {OP_BE, OP_BNE};
    assign is_jmp = (opcode == OP_JMP);

    always_comb begin
        op_class = CLS_ILL;
        unique case (1'b1)
            is_r:    op_class = CLS_R;
            is_i:    op_class = CLS_I;
            is_mem:  op_class = CLS_MEM;
            is_br:   op_class = CLS_BR;
            is_jmp:  op_class = CLS_JMP;
            default: op_class = CLS_ILL;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB, OP_SUBI, OP_SUBIZ: alu_op = ALU_SUB;
            OP_NAND, OP_NANDI:         alu_op = ALU_NAND;
            OP_OR, OP_ORI:             alu_op = ALU_OR;
            OP_FUNC: begin
                case (funcfield)
                    FUNC_SHL: alu_op = ALU_SHL;
                    FUNC_SHR: alu_op = ALU_SHR;
                    FUNC_SAR: alu_op = ALU_SAR;
                    default:  alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    // Address offsets and the signed immediates are sign-extended
    assign ext_sel = opcode inside {OP_ADDI, OP_SUBI, OP_LW, OP_SW};

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control FSM: sequences datapath controls per
// instruction class and stalls on the memory-ready handshake.
module control_fsm
    import proc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] OPCODE,
    input  logic [3:0] FUNCFIELD,
    input  logic       I_MemReady,
    output logic       C_IRWrite,
    output logic       C_PCWrite,
    output logic       C_PCWriteCond,
    output logic       C_PCWriteCondNE,
    output logic       C_MemRead,
    output logic       C_MemWrite,
    output logic       C_IorD,
    output logic       C_RegWrite,
    output logic       C_MemtoReg,
    output logic       C_ALUSrcA,
    output logic       C_ExtSel,
    output logic [1:0] C_ALUSrcB,
    output logic [2:0] C_ALUOp,
    output logic [1:0] C_PCSource,
    output logic       C_Illegal
);

    state_t     state;
    state_t     nxt;
    opclass_t   cls;
    logic [2:0] cls_alu_op;
    logic       cls_ext;

    ctrl_opclass u_opclass (
        .opcode    (OPCODE),
        .funcfield (FUNCFIELD),
        .op_class  (cls),
        .alu_op    (cls_alu_op),
        .ext_sel   (cls_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= nxt;
    end

    always_comb begin
        nxt             = state;
        C_IRWrite       = 1'b0;
        C_PCWrite       = 1'b0;
        C_PCWriteCond   = 1'b0;
        C_PCWriteCondNE = 1'b0;
        C_MemRead       = 1'b0;
        C_MemWrite      = 1'b0;
        C_IorD          = 1'b0;
        C_RegWrite      = 1'b0;
        C_MemtoReg      = 1'b0;
        C_ALUSrcA       = 1'b0;
        C_ExtSel        = 1'b0;
        C_ALUSrcB       = SRCB_REG;
        C_ALUOp         = ALU_ADD;
        C_PCSource      = PCS_ALU;
        C_Illegal       = 1'b0;
        case (state)
            FETCH: begin
                C_MemRead = 1'b1;
                C_ALUSrcB = SRCB_ONE;
                C_IRWrite = I_MemReady;
                C_PCWrite = I_MemReady;
                if (I_MemReady) nxt = DECODE;
            end
            DECODE: begin
                C_ALUSrcB = SRCB_OFS;
                unique case (cls)
                    CLS_R:   nxt = EXEC_R;
                    CLS_I:   nxt = EXEC_I;
                    CLS_MEM: nxt = MEMADR;
                    CLS_BR:  nxt = BRANCH;
                    CLS_JMP: nxt = JUMP;
                    default: begin
                        nxt       = FETCH;
                        C_Illegal = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                C_ALUSrcA = 1'b1;
                C_ALUOp   = cls_alu_op;
                nxt       = ALUWB;
            end
            EXEC_I: begin
                C_ALUSrcA = 1'b1;
                C_ALUSrcB = SRCB_IMM;
                C_ExtSel  = cls_ext;
                C_ALUOp   = cls_alu_op;
                nxt       = ALUWB;
            end
            ALUWB: begin
                C_RegWrite = 1'b1;
                nxt        = FETCH;
            end
            MEMADR: begin
                C_ALUSrcA = 1'b1;
                C_ALUSrcB = SRCB_IMM;
                C_ExtSel  = 1'b1;
                nxt       = (OPCODE == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                C_MemRead = 1'b1;
                C_IorD    = 1'b1;
                if (I_MemReady) nxt = MEMWB;
            end
            MEMWB: begin
                C_RegWrite = 1'b1;
                C_MemtoReg = 1'b1;
                nxt        = FETCH;
            end
            MEMWR: begin
                C_MemWrite = 1'b1;
                C_IorD     = 1'b1;
                if (I_MemReady) nxt = FETCH;
            end
            BRANCH: begin
                C_ALUSrcA       = 1'b1;
                C_ALUOp         = ALU_SUB;
                C_PCSource      = PCS_ALUOUT;
                C_PCWriteCond   = (OPCODE == OP_BE);
                C_PCWriteCondNE = (OPCODE == OP_BNE);
                nxt             = FETCH;
            end
            JUMP: begin
                C_PCWrite  = 1'b1;
                C_PCSource = PCS_JUMP;
                nxt        = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // Reset holds every control line low, including write strobes
        if (!rst) begin
            C_IRWrite       = 1'b0;
            C_PCWrite       = 1'b0;
            C_PCWriteCond   = 1'b0;
            C_PCWriteCondNE = 1'b0;
            C_MemRead       = 1'b0;
            C_MemWrite      = 1'b0;
            C_IorD          = 1'b0;
            C_RegWrite      = 1'b0;
            C_MemtoReg      = 1'b0;
            C_ALUSrcA       = 1'b0;
            C_ExtSel        = 1'b0;
            C_ALUSrcB       = SRCB_REG;
            C_ALUOp         = ALU_ADD;
            C_PCSource      = PCS_ALU;
            C_Illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected control
// vectors are queued with the stimulus and compared at negedge.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] OPCODE;
    logic [3:0] FUNCFIELD;
    logic       I_MemReady;
    logic       C_IRWrite, C_PCWrite, C_PCWriteCond, C_PCWriteCondNE;
    logic       C_MemRead, C_MemWrite, C_IorD, C_RegWrite;
    logic       C_MemtoReg, C_ALUSrcA, C_ExtSel, C_Illegal;
    logic [1:0] C_ALUSrcB, C_PCSource;
    logic [2:0] C_ALUOp;

    typedef logic [18:0] ov_t;
    typedef logic [8:0]  stim_t;

    ov_t   exp_q[$];
    stim_t stim_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .OPCODE          (OPCODE),
        .FUNCFIELD       (FUNCFIELD),
        .I_MemReady      (I_MemReady),
        .C_IRWrite       (C_IRWrite),
        .C_PCWrite       (C_PCWrite),
        .C_PCWriteCond   (C_PCWriteCond),
        .C_PCWriteCondNE (C_PCWriteCondNE),
        .C_MemRead       (C_MemRead),
        .C_MemWrite      (C_MemWrite),
        .C_IorD          (C_IorD),
        .C_RegWrite      (C_RegWrite),
        .C_MemtoReg      (C_MemtoReg),
        .C_ALUSrcA       (C_ALUSrcA),
        .C_ExtSel        (C_ExtSel),
        .C_ALUSrcB       (C_ALUSrcB),
        .C_ALUOp         (C_ALUOp),
        .C_PCSource      (C_PCSource),
        .C_Illegal       (C_Illegal)
    );

    function automatic ov_t observed();
        return {C_IRWrite, C_PCWrite, C_PCWriteCond, C_PCWriteCondNE,
                C_MemRead, C_MemWrite, C_IorD, C_RegWrite, C_MemtoReg,
                C_ALUSrcA, C_ExtSel, C_ALUSrcB, C_ALUOp, C_PCSource,
                C_Illegal};
    endfunction

    // Field order: irw pcw pcc pcne mrd mwr iord rw m2r srca ext srcb op pcs ill
    function automatic ov_t pk(
        input logic irw, pcw, pcc, pcne, mrd, mwr, iord, rw, m2r,
        input logic srca, ext, input logic [1:0] srcb,
        input logic [2:0] op, input logic [1:0] pcs, input logic ill);
        return {irw, pcw, pcc, pcne, mrd, mwr, iord, rw, m2r,
                srca, ext, srcb, op, pcs, ill};
    endfunction

    task automatic check(input string tag, input ov_t got, input ov_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    function automatic logic [2:0] ref_aluop(input logic [3:0] op,
                                              input logic [3:0] fn);
        case (op)
            4'b1100, 4'b1101, 4'b1110: return 3'b001;
            4'b1011, 4'b0111:          return 3'b101;
            4'b1111, 4'b0110:          return 3'b110;
            4'b0000: begin
                if (fn == 4'b0001) return 3'b010;
                if (fn == 4'b0010) return 3'b011;
                if (fn == 4'b0011) return 3'b100;
                return 3'b000;
            end
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input logic [3:0] op, input logic [3:0] fn,
                        input logic mr, input ov_t e);
        stim_q.push_back({op, fn, mr});
        exp_q.push_back(e);
    endtask

    // Queue one instruction: fstall FETCH wait cycles, mstall memory waits
    task automatic add_instr(input logic [3:0] op, input logic [3:0] fn,
                             input int fstall, input int mstall);
        logic [2:0] a;
        a = ref_aluop(op, fn);
        for (int i = 0; i < fstall; i++)
            push(op, fn, 1'b0, pk(0,0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0));
        push(op, fn, 1'b1, pk(1,1,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0));
        if (op == 4'b0000 && !(fn inside {4'b0001, 4'b0010, 4'b0011})) begin
            push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1));
            return;
        end
        push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0));
        case (op)
            4'b1000, 4'b1011, 4'b1100, 4'b1111, 4'b0000: begin
                push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,0,0,1,0,2'b00,a,2'b00,0));
                push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00,0));
            end
            4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0110, 4'b0111: begin
                push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,0,0,1,
                                      (op == 4'b1001 || op == 4'b1101),
                                      2'b10,a,2'b00,0));
                push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00,0));
            end
            4'b0001, 4'b0010: begin
                push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,0,0,1,1,2'b10,3'b000,2'b00,0));
                for (int i = 0; i <= mstall; i++) begin
                    if (op == 4'b0001)
                        push(op, fn, (i == mstall),
                             pk(0,0,0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0));
                    else
                        push(op, fn, (i == mstall),
                             pk(0,0,0,0,0,1,1,0,0,0,0,2'b00,3'b000,2'b00,0));
                end
                if (op == 4'b0001)
                    push(op, fn, 1'b1, pk(0,0,0,0,0,0,0,1,1,0,0,2'b00,3'b000,2'b00,0));
            end
            4'b0100, 4'b0101:
                push(op, fn, 1'b1, pk(0,0,(op == 4'b0100),(op == 4'b0101),
                                      0,0,0,0,0,1,0,2'b00,3'b001,2'b01,0));
            default:
                push(op, fn, 1'b1, pk(0,1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0));
        endcase
    endtask

    task automatic run_cycles(input int n, input string tag);
        stim_t s;
        ov_t   e;
        for (int i = 0; i < n && stim_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            {OPCODE, FUNCFIELD, I_MemReady} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s[op=%b fn=%b]", tag, s[8:5], s[4:1]),
                  observed(), e);
        end
    endtask

    initial begin
        rst        = 1'b0;
        OPCODE     = 4'b0000;
        FUNCFIELD  = 4'b0000;
        I_MemReady = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", observed(), '0);
        rst        = 1'b1;
        I_MemReady = 1'b0;
        #1;
        check("release_fetch", observed(),
              pk(0,0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0));

        add_instr(4'b1000, 4'b0000, 0, 0);
        add_instr(4'b0000, 4'b0011, 0, 0);
        add_instr(4'b0000, 4'b0101, 0, 0);
        add_instr(4'b0001, 4'b0000, 0, 2);
        add_instr(4'b1110, 4'b0000, 0, 0);
        add_instr(4'b1101, 4'b0000, 0, 0);
        add_instr(4'b0100, 4'b0000, 0, 0);
        add_instr(4'b0101, 4'b0000, 0, 0);
        add_instr(4'b0011, 4'b0000, 0, 0);
        add_instr(4'b0010, 4'b0000, 1, 1);
        add_instr(4'b1011, 4'b0000, 2, 0);
        add_instr(4'b0110, 4'b0000, 0, 0);
        add_instr(4'b0000, 4'b0001, 0, 0);
        add_instr(4'b1010, 4'b0000, 0, 0);
        add_instr(4'b0001, 4'b0000, 0, 0);
        run_cycles(1000, "seq");

        // Abort a stalled store: FETCH, DECODE, MEMADR, then MEMWR
        add_instr(4'b0010, 4'b0000, 0, 3);
        run_cycles(4, "sw_pre");
        check("in_memwr", observed(),
              pk(0,0,0,0,0,1,1,0,0,0,0,2'b00,3'b000,2'b00,0));
        #2 rst = 1'b0;
        #1;
        check("reset_mid_memwr", observed(), '0);
        @(posedge clk);
        #1;
        check("reset_held", observed(), '0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst        = 1'b1;
        I_MemReady = 1'b0;
        #1;
        check("refetch", observed(),
              pk(0,0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0));
        add_instr(4'b0011, 4'b0000, 0, 0);
        add_instr(4'b1111, 4'b0000, 0, 0);
        run_cycles(1000, "post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit for the 16-bit processor. It sits directly downstream of the instruction register, consumes OPCODE/FUNCFIELD and sequences every datapath control line, including C_IRWrite back to the instruction register. It stalls on a memory-ready handshake and flags illegal encodings.

## Interface
- No parameters. Opcode, ALUOp and state encodings are package constants.
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- OPCODE  input  4  from instruction register
- FUNCFIELD  input  4  from instruction register; meaningful only for OPCODE 0000
- I_MemReady  input  1  memory completes current read/write this cycle
- C_IRWrite, C_PCWrite, C_PCWriteCond, C_PCWriteCondNE  output  1 each  IR load, unconditional PC write, PC write if zero, PC write if not zero
- C_MemRead, C_MemWrite, C_IorD  output  1 each  memory strobes; address select (0 = PC, 1 = ALUOut)
- C_RegWrite, C_MemtoReg, C_ALUSrcA, C_ExtSel  output  1 each  register write; write-data select (1 = MDR); ALU A select (0 = PC, 1 = reg); immediate extend (1 = sign, 0 = zero)
- C_ALUSrcB  output  2  00 reg, 01 constant 1, 10 immediate, 11 sign-extended offset
- C_ALUOp  output  3  000 add, 001 sub, 010 shl, 011 shr, 100 sar, 101 nand, 110 or
- C_PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- C_Illegal  output  1  one-cycle pulse on undefined encoding

## Operation
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP.
- Outputs are decoded combinationally from the state register, OPCODE, FUNCFIELD and I_MemReady. Any output not listed for a state is 0.
- FETCH:
  - Outputs: C_MemRead=1, C_IorD=0, C_ALUSrcA=0, C_ALUSrcB=01, C_ALUOp=add, C_PCSource=00.
  - C_IRWrite and C_PCWrite = I_MemReady.
  - Transition: to DECODE when I_MemReady=1, else hold.
- DECODE:
  - Outputs: C_ALUSrcA=0, C_ALUSrcB=11, C_ALUOp=add (branch target into ALUOut).
  - Transitions:
    - OPCODE 1000/1011/1100/1111, or 0000 with FUNCFIELD 0001–0011 → EXEC_R.
    - 1001/1010/1101/1110/0110/0111 → EXEC_I.
    - 0001/0010 → MEMADR.
    - 0100/0101 → BRANCH.
    - 0011 → JUMP.
    - 0000 with any other FUNCFIELD → FETCH, with C_Illegal=1.
- EXEC_R:
  - Outputs: C_ALUSrcA=1, C_ALUSrcB=00.
  - C_ALUOp: add 1000, sub 1100, nand 1011, or 1111, FUNCFIELD 0001/0010/0011 → shl/shr/sar.
  - Transition: → ALUWB.
- EXEC_I:
  - Outputs: C_ALUSrcA=1, C_ALUSrcB=10.
  - C_ExtSel=1 for 1001/1101, 0 for 1010/1110/0110/0111.
  - C_ALUOp: add 1001/1010, sub 1101/1110, or 0110, nand 0111.
  - Transition: → ALUWB.
- ALUWB: C_RegWrite=1, C_MemtoReg=0 → FETCH.
- MEMADR:
  - Outputs: C_ALUSrcA=1, C_ALUSrcB=10, C_ExtSel=1, C_ALUOp=add.
  - Transition: → MEMRD (0001) or MEMWR (0010).
- MEMRD: C_MemRead=1, C_IorD=1; hold until I_MemReady=1, then → MEMWB.
- MEMWB: C_RegWrite=1, C_MemtoReg=1 → FETCH.
- MEMWR: C_MemWrite=1, C_IorD=1; hold until I_MemReady=1, then → FETCH.
- BRANCH:
  - Outputs: C_ALUSrcA=1, C_ALUSrcB=00, C_ALUOp=sub, C_PCSource=01.
  - C_PCWriteCond=1 for 0100, C_PCWriteCondNE=1 for 0101.
  - Transition: → FETCH.
- JUMP: C_PCWrite=1, C_PCSource=10 → FETCH.

## Timing
- Reset (rst=0): state=FETCH immediately, asynchronously. All outputs forced to 0 while rst=0.
- First FETCH outputs appear in the cycle after rst deasserts.
- Deassertion may be asynchronous to clk. No transition is taken on the edge coinciding with deassertion if setup is violated, so the deassertion must be synchronized upstream.
- Zero-wait latency, cycles from FETCH entry to next FETCH entry:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - be, bne, jmp: 3
- Each cycle of I_MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- C_IRWrite, C_PCWrite, C_PCWriteCond, C_PCWriteCondNE, C_MemWrite and C_RegWrite are never asserted in the same cycle as C_Illegal.
- OPCODE/FUNCFIELD must be stable from DECODE through the last state of the instruction. The IR is only written in FETCH.
- rst asserted mid-instruction aborts it. No write strobe is asserted while rst=0.

## Structure
- Package proc_ctrl_pkg holds:
  - opcode constants (OP_ADD=4'b1000 … OP_SW=4'b0010)
  - FUNC_SHL/SHR/SAR
  - ALUOp codes
  - ALUSrcB and PCSource codes
  - state encodings
- One sub-module, ctrl_opclass: combinational classifier taking OPCODE/FUNCFIELD and producing instruction class (R, I, MEM, BR, JMP, ILL), ALUOp and ExtSel. It is shared by the DECODE and EXEC states.

## Test plan
- Reset: rst=0 mid-MEMWR → all outputs 0 immediately. After release, FETCH with C_MemRead=1, C_IorD=0.
- add (OPCODE 1000), I_MemReady=1: FETCH → DECODE → EXEC_R (C_ALUOp=000, C_ALUSrcB=00) → ALUWB (C_RegWrite=1) → FETCH, 4 cycles.
- sar (OPCODE 0000, FUNCFIELD 0011) gives C_ALUOp=100. OPCODE 0000 with FUNCFIELD 0101 → C_Illegal pulse in DECODE, next state FETCH, no C_RegWrite.
- lw (0001), I_MemReady=0 for 2 cycles in MEMRD: C_MemRead=1, C_IorD=1 held 3 cycles, then MEMWB (C_RegWrite=1, C_MemtoReg=1); total 7 cycles.
- subimz (1110) → C_ExtSel=0, C_ALUOp=001, C_ALUSrcB=10. subimex (1101) → C_ExtSel=1.
- be (0100) → BRANCH with C_PCWriteCond=1, C_PCWriteCondNE=0, C_PCSource=01. jmp (0011) → C_PCWrite=1, C_PCSource=10; each 3 cycles.
